pipe_trace_buffer: RTL
======================

// Module: pipe_trace_buffer
// PURPOSE
//  On-chip trace capture for the pipelined RISC-V core. It replaces per-cycle $display probing
//  of ID-stage signals (PC, inst, type, ImmSel) with a parametrised circular record buffer.
//  The buffer is armed by software or the bench, optionally triggered on a PC match,
//  captures a programmable post-trigger window, and is drained through a valid/ready port.
//  It sits beside the ID stage and only observes; it never stalls the pipeline.
// PARAMETERS
//  DEPTH   16  records stored; power of two, >=2
//  PC_W    32  PC field width
//  INST_W  32  instruction field width
//  CNT_W   $clog2(DEPTH)+1  width of count and post_count
// PORTS
//  clk         in   1        core clock, rising edge
//  rst_n       in   1        asynchronous active-low reset
//  arm         in   1        pulse: clear buffer, enter ARMED (any state, highest priority)
//  mode        in   1        0=wrap (overwrite oldest), 1=one-shot (stop when full); sampled at arm
//  trig_en     in   1        enable PC-match trigger
//  trig_pc     in   PC_W     trigger PC
//  post_count  in   CNT_W    records captured after the trigger record; sampled at trigger
//  cap_valid   in   1        ID-stage record valid this cycle
//  cap_pc      in   PC_W     PC_ID
//  cap_inst    in   INST_W   inst_ID
//  cap_type    in   3        type_ID
//  cap_immsel  in   3        ImmSel
//  rd_valid    out  1        readout record available
//  rd_ready    in   1        consumer accepts record
//  rd_pc/rd_inst/rd_type/rd_immsel  out  PC_W/INST_W/3/3  record at read pointer
//  rd_last     out  1        current record is the final one
//  state       out  3        FSM state (encoding from package)
//  count       out  CNT_W    records held, saturates at DEPTH
//  overflow    out  1        wrap mode overwrote at least one record since arm
// BEHAVIOUR
//  Reset: state=IDLE, wr_ptr=rd_ptr=0, count=0, overflow=0, rd_valid=0, rd_last=0, rd_* = 0.
//  States: IDLE -> ARMED -> POST -> DONE -> IDLE.
//  IDLE: cap_valid ignored. arm -> ARMED.
//  arm in any state: next cycle ARMED, wr_ptr=0, count=0, overflow=0, and mode latched.
//    This aborts a readout in progress.
//  Write: in ARMED/POST with cap_valid, record written at wr_ptr on the same edge.
//    wr_ptr+1 mod DEPTH. count+1, saturating at DEPTH.
//    A write when count==DEPTH in wrap mode sets overflow=1.
//  ARMED, one-shot mode: the write that makes count==DEPTH -> DONE.
//  ARMED, trigger: trig_en & cap_valid & cap_pc==trig_pc. The trigger record is written.
//    remain=min(post_count,DEPTH-1).
//    remain==0 -> DONE, else -> POST.
//  POST: each write decrements remain; remain hits 0 -> DONE. One-shot mode: full -> DONE.
//    Further matches are ignored.
//  DONE entry: rd_ptr = (count==DEPTH) ? wr_ptr : 0, giving oldest-first order.
//    rd_left=count. Captures are off.
//  DONE: rd_valid=1 while rd_left>0. rd_* are read combinationally from storage at rd_ptr.
//    rd_last=(rd_left==1).
//    Transfer on rd_valid&rd_ready: rd_ptr+1 mod DEPTH, rd_left-1.
//    After the rd_last transfer: next cycle IDLE, rd_valid=0. count holds until the next arm.
//  rd_* hold stable while rd_valid&!rd_ready.
//  Simultaneous trigger and fill in one-shot mode: DONE (fill wins).
//    The same applies when post_count exceeds the free space.
//  No trigger in wrap mode: capture runs until the next arm.
// STRUCTURE
//  Package pipe_trace_pkg:
//    state localparams IDLE=0, ARMED=1, POST=2, DONE=3.
//    record field offsets and REC_W=PC_W+INST_W+6.
//  Sub-module trace_mem: DEPTH x REC_W flop array, one sync write port, one async read port.
//    No reset on the storage array.
//  FSM, pointers and counters live in pipe_trace_buffer.
// TESTING (DEPTH=16)
//  1. One-shot, trig_en=0, 20 valids with PC 0x00..0x4C step 4.
//     -> DONE after the 16th write, count=16, readout PC 0x00..0x3C, rd_last on 0x3C.
//  2. Wrap, trig_en=1, trig_pc=0x40, post_count=3, PCs 0x00 upward.
//     -> readout of 16 records, PC 0x10..0x4C, overflow=1.
//  3. Trigger on the first valid, post_count=0.
//     -> DONE next cycle, count=1, single record with rd_last=1.
//  4. Readout with rd_ready toggled 1,0,0,1.
//     -> no record duplicated or lost; rd_* stable while stalled.
//  5. arm mid-readout after 5 transfers.
//     -> next cycle ARMED, count=0, rd_valid=0.
//  6. Reset asserted in POST with remain=2.
//     -> immediately IDLE, all outputs 0. After release, cap_valid is ignored until arm.

Source files
------------

// File: rtl/pipe_trace_pkg.sv
// Shared definitions for the ID-stage trace buffer: state encoding, record layout and defaults.
// The record is packed as {pc, inst, type, immsel}, with immsel in the least significant bits.
package pipe_trace_pkg;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_PC_W   = 32;
  localparam int DEF_INST_W = 32;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARMED = 3'd1;
  localparam logic [2:0] POST  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE  = IDLE,
    S_ARMED = ARMED,
    S_POST  = POST,
    S_DONE  = DONE
  } state_t;

  // type and immsel are 3 bits each and sit below the instruction word
  localparam int IMMSEL_LSB = 0;
  localparam int TYPE_LSB   = 3;
  localparam int INST_LSB   = 6;
  localparam int FIXED_W    = 6;

  localparam int REC_W = DEF_PC_W + DEF_INST_W + FIXED_W;

  function automatic int rec_width(input int pc_w, input int inst_w);
    return pc_w + inst_w + FIXED_W;
  endfunction

  function automatic int pc_lsb(input int inst_w);
    return INST_LSB + inst_w;
  endfunction

endpackage

// File: rtl/pipe_trace_buffer_mem.sv
// Record storage: DEPTH rows of flops with one synchronous write port and one asynchronous read port.
// Rows carry no reset; their contents are only meaningful once written after an arm.
module pipe_trace_buffer_mem
  import pipe_trace_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int REC_W_P = REC_W,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [REC_W_P-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [REC_W_P-1:0] rdata
);

  logic [REC_W_P-1:0] rows [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_row
      logic [REC_W_P-1:0] row_reg;

      always_ff @(posedge clk) begin
        if (we && (waddr == AW'(gi))) begin
          row_reg <= wdata;
        end
      end

      assign rows[gi] = row_reg;
    end
  endgenerate

  assign rdata = rows[raddr];

endmodule

// File: rtl/pipe_trace_buffer.sv
// Circular trace capture of ID-stage records with arm, optional PC trigger, post-trigger window
// and a valid/ready readout that presents records oldest first. Purely observational.
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PC_W   = DEF_PC_W,
  parameter int INST_W = DEF_INST_W,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              mode,
  input  logic              trig_en,
  input  logic [PC_W-1:0]   trig_pc,
  input  logic [CNT_W-1:0]  post_count,
  input  logic              cap_valid,
  input  logic [PC_W-1:0]   cap_pc,
  input  logic [INST_W-1:0] cap_inst,
  input  logic [2:0]        cap_type,
  input  logic [2:0]        cap_immsel,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [PC_W-1:0]   rd_pc,
  output logic [INST_W-1:0] rd_inst,
  output logic [2:0]        rd_type,
  output logic [2:0]        rd_immsel,
  output logic              rd_last,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int RW  = rec_width(PC_W, INST_W);
  localparam int PCL = pc_lsb(INST_W);
  localparam logic [CNT_W-1:0] FULL       = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_REMAIN = CNT_W'(DEPTH - 1);

  state_t           state_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] remain_reg;
  logic [CNT_W-1:0] rd_left_reg;
  logic             overflow_reg;
  logic             oneshot_reg;

  logic             capturing;
  logic             wr_en;
  logic             trig_hit;
  logic             full_after;
  logic             go_done;
  logic             go_post;
  logic             xfer;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] remain_init;
  logic [AW-1:0]    wr_ptr_inc;
  logic [AW-1:0]    done_rd_ptr;
  logic [RW-1:0]    wdata;
  logic [RW-1:0]    rdata;

  always_comb begin
    capturing   = (state_reg == S_ARMED) || (state_reg == S_POST);
    wr_en       = capturing && cap_valid && !arm;
    count_inc   = (count_reg == FULL) ? FULL : count_reg + CNT_W'(1);
    full_after  = (count_inc == FULL);
    wr_ptr_inc  = wr_ptr_reg + AW'(1);
    trig_hit    = (state_reg == S_ARMED) && trig_en && (cap_pc == trig_pc);
    remain_init = (post_count > MAX_REMAIN) ? MAX_REMAIN : post_count;
    // a full buffer rewinds to the oldest entry, which is the slot about to be overwritten
    done_rd_ptr = full_after ? wr_ptr_inc : '0;
    go_done     = 1'b0;
    go_post     = 1'b0;
    if (wr_en) begin
      if (oneshot_reg && full_after) begin
        go_done = 1'b1;
      end else if (trig_hit) begin
        if (remain_init == '0) begin
          go_done = 1'b1;
        end else begin
          go_post = 1'b1;
        end
      end else if ((state_reg == S_POST) && (remain_reg == CNT_W'(1))) begin
        go_done = 1'b1;
      end
    end
  end

  assign rd_valid = (state_reg == S_DONE) && (rd_left_reg != '0);
  assign rd_last  = rd_valid && (rd_left_reg == CNT_W'(1));
  assign xfer     = rd_valid && rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      remain_reg   <= '0;
      rd_left_reg  <= '0;
      overflow_reg <= 1'b0;
      oneshot_reg  <= 1'b0;
    end else if (arm) begin
      state_reg    <= S_ARMED;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      remain_reg   <= '0;
      rd_left_reg  <= '0;
      overflow_reg <= 1'b0;
      oneshot_reg  <= mode;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_inc;
        count_reg  <= count_inc;
        if (!oneshot_reg && (count_reg == FULL)) begin
          overflow_reg <= 1'b1;
        end
      end
      if (go_done) begin
        state_reg   <= S_DONE;
        rd_ptr_reg  <= done_rd_ptr;
        rd_left_reg <= count_inc;
      end else if (go_post) begin
        state_reg  <= S_POST;
        remain_reg <= remain_init;
      end else if (wr_en && (state_reg == S_POST)) begin
        remain_reg <= remain_reg - CNT_W'(1);
      end
      if (xfer) begin
        rd_ptr_reg  <= rd_ptr_reg + AW'(1);
        rd_left_reg <= rd_left_reg - CNT_W'(1);
        if (rd_left_reg == CNT_W'(1)) begin
          state_reg <= S_IDLE;
        end
      end
    end
  end

  assign wdata[PCL +: PC_W]        = cap_pc;
  assign wdata[INST_LSB +: INST_W] = cap_inst;
  assign wdata[TYPE_LSB +: 3]      = cap_type;
  assign wdata[IMMSEL_LSB +: 3]    = cap_immsel;

  pipe_trace_buffer_mem #(
    .DEPTH   (DEPTH),
    .REC_W_P (RW),
    .AW      (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_reg),
    .wdata (wdata),
    .raddr (rd_ptr_reg),
    .rdata (rdata)
  );

  // unwritten rows are undefined, so the port shows zeros whenever nothing is offered
  assign rd_pc     = rd_valid ? rdata[PCL +: PC_W]        : '0;
  assign rd_inst   = rd_valid ? rdata[INST_LSB +: INST_W] : '0;
  assign rd_type   = rd_valid ? rdata[TYPE_LSB +: 3]      : '0;
  assign rd_immsel = rd_valid ? rdata[IMMSEL_LSB +: 3]    : '0;

  assign state    = state_reg;
  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule
